// File: rtl/fetch_unit.sv
// Instruction fetch unit: a program-load phase fills a word-addressed instruction
// memory, then a run phase streams {pc, instruction} pairs to decode with redirect and stall.
module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter int unsigned     ILEN       = 32,
    parameter int unsigned     IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [ILEN-1:0] wr_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [ILEN-1:0] out_ins,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_next_pc,
    output logic            fault,
    output logic            busy
);

    localparam int unsigned     AW      = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    // Legal byte address: word aligned and every bit above the word index clear
    // (assumes XLEN > AW + 2, so an out-of-range address can never alias a real word).
    function automatic logic addr_legal(input logic [XLEN-1:0] addr);
        addr_legal = (addr[1:0] == 2'b00) && (addr[XLEN-1:AW+2] == '0);
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [XLEN-1:0] addr);
        word_idx = addr[AW+1:2];
    endfunction

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [ILEN-1:0]   out_ins_q, out_ins_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              fault_q, fault_d;
    logic              mem_we_s;
    logic [ILEN-1:0]   imem_q [IMEM_DEPTH];

    // Next-state, PC and output-register computation.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_ins_d   = out_ins_q;
        out_pc_d    = out_pc_q;
        fault_d     = fault_q;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                out_valid_d = 1'b0;
                if (wr_en && addr_legal(wr_addr)) begin
                    mem_we_s = 1'b1;
                end else begin
                    mem_we_s = 1'b0;
                end
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                // Redirect wins over both fetch and stall and squashes the held output.
                if (redirect_valid) begin
                    pc_d        = redirect_pc;
                    out_valid_d = 1'b0;
                end else if (!out_valid_q || out_ready) begin
                    if (addr_legal(pc_q)) begin
                        out_ins_d   = imem_q[word_idx(pc_q)];
                        out_pc_d    = pc_q;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + PC_STEP;
                    end else begin
                        state_d     = ST_FAULT;
                        fault_d     = 1'b1;
                        out_valid_d = 1'b0;
                    end
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            ST_FAULT: begin
                out_valid_d = 1'b0;
                fault_d     = 1'b1;
            end
            default: begin
                state_d     = ST_LOAD;
                pc_d        = RESET_PC;
                out_valid_d = 1'b0;
                fault_d     = 1'b0;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_LOAD;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_ins_q   <= '0;
            out_pc_q    <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_ins_q   <= out_ins_d;
            out_pc_q    <= out_pc_d;
            fault_q     <= fault_d;
        end
    end

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge CLK) begin
        if (RST && mem_we_s) begin
            imem_q[word_idx(wr_addr)] <= wr_data;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ins     = out_ins_q;
    assign out_pc      = out_pc_q;
    assign out_next_pc = out_pc_q + PC_STEP;
    assign fault       = fault_q;
    assign busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: load, stream, stall, redirect,
// fault paths and reset behaviour with hand-computed expectations.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic        fault;
    logic        busy;

    int checks_s = 0;
    int errors_s = 0;

    fetch_unit #(
        .XLEN(32), .ILEN(32), .IMEM_DEPTH(64), .RESET_PC(32'h0000_0000)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(out_valid), .out_ins(out_ins), .out_pc(out_pc),
        .out_next_pc(out_next_pc), .fault(fault), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_s++;
        if (got !== exp) begin
            errors_s++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check_eq({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check_eq({tag, ".pc"}, {32'd0, out_pc}, {32'd0, pc});
        check_eq({tag, ".ins"}, {32'd0, out_ins}, {32'd0, ins});
        check_eq({tag, ".next"}, {32'd0, out_next_pc}, {32'd0, pc + 32'd4});
    endtask

    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        RST = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        RST = 1'b0; start = 1'b0; wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0;
        redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0;
        tick();
        tick();
        check_eq("rst.valid", {63'd0, out_valid}, 64'd0);
        check_eq("rst.ins", {32'd0, out_ins}, 64'd0);
        check_eq("rst.pc", {32'd0, out_pc}, 64'd0);
        check_eq("rst.fault", {63'd0, fault}, 64'd0);
        check_eq("rst.busy", {63'd0, busy}, 64'd0);
        RST = 1'b1;

        // Program load, two illegal writes that must be dropped, last write with start.
        load_word(32'h0, 32'h11);
        load_word(32'h4, 32'h22);
        load_word(32'h8, 32'h33);
        load_word(32'h100, 32'hEE);
        load_word(32'h1, 32'hDD);
        check_eq("load.valid", {63'd0, out_valid}, 64'd0);
        check_eq("load.busy", {63'd0, busy}, 64'd0);
        wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'h44; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0; out_ready = 1'b1;
        check_eq("start.busy", {63'd0, busy}, 64'd1);
        check_eq("start.valid", {63'd0, out_valid}, 64'd0);

        tick(); expect_out("seq0", 32'h0, 32'h11);
        tick(); expect_out("seq1", 32'h4, 32'h22);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_out("stall", 32'h4, 32'h22);
        end
        out_ready = 1'b1;
        tick(); expect_out("seq2", 32'h8, 32'h33);
        tick(); expect_out("seq3", 32'hC, 32'h44);

        // Get back to out_pc=4, then redirect to 0x0C with out_ready high.
        redirect_to(32'h4);
        tick(); expect_out("rd4", 32'h4, 32'h22);
        redirect_to(32'hC);
        check_eq("rdC.squash", {63'd0, out_valid}, 64'd0);
        tick(); expect_out("rdC", 32'hC, 32'h44);

        // Redirect during a stall.
        out_ready = 1'b0;
        redirect_to(32'h0);
        check_eq("rdstall.squash", {63'd0, out_valid}, 64'd0);
        tick(); expect_out("rdstall", 32'h0, 32'h11);
        out_ready = 1'b1;

        // Writes and start in RUN must be ignored.
        wr_en = 1'b1; wr_addr = 32'h0; wr_data = 32'hDEAD; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        check_eq("runwr.busy", {63'd0, busy}, 64'd1);

        // Misaligned redirect target faults only on the following fetch.
        redirect_to(32'h6);
        check_eq("mis.nofault", {63'd0, fault}, 64'd0);
        check_eq("mis.busy", {63'd0, busy}, 64'd1);
        tick();
        check_eq("mis.fault", {63'd0, fault}, 64'd1);
        check_eq("mis.valid", {63'd0, out_valid}, 64'd0);
        check_eq("mis.busy0", {63'd0, busy}, 64'd0);
        redirect_to(32'h0);
        tick();
        check_eq("mis.sticky", {63'd0, fault}, 64'd1);
        check_eq("mis.stvalid", {63'd0, out_valid}, 64'd0);

        do_reset();
        check_eq("rst2.fault", {63'd0, fault}, 64'd0);
        check_eq("rst2.busy", {63'd0, busy}, 64'd0);
        check_eq("rst2.pc", {32'd0, out_pc}, 64'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); expect_out("keep0", 32'h0, 32'h11);

        // Walk off the end of memory: 0xFC is the last legal word.
        redirect_to(32'hFC);
        tick();
        check_eq("end.valid", {63'd0, out_valid}, 64'd1);
        check_eq("end.pc", {32'd0, out_pc}, 64'hFC);
        check_eq("end.next", {32'd0, out_next_pc}, 64'h100);
        check_eq("end.nofault", {63'd0, fault}, 64'd0);
        tick();
        check_eq("oob.fault", {63'd0, fault}, 64'd1);
        check_eq("oob.valid", {63'd0, out_valid}, 64'd0);
        check_eq("oob.busy", {63'd0, busy}, 64'd0);
        redirect_to(32'h0);
        tick();
        check_eq("oob.sticky", {63'd0, fault}, 64'd1);
        check_eq("oob.stvalid", {63'd0, out_valid}, 64'd0);
        do_reset();
        check_eq("oob.rst", {63'd0, fault}, 64'd0);

        // Reset in the middle of a stall with a write strobe present.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); expect_out("pre", 32'h0, 32'h11);
        out_ready = 1'b0;
        tick(); expect_out("prestall", 32'h0, 32'h11);
        wr_en = 1'b1; wr_addr = 32'h4; wr_data = 32'h99; RST = 1'b0;
        tick();
        wr_en = 1'b0; RST = 1'b1;
        check_eq("mid.valid", {63'd0, out_valid}, 64'd0);
        check_eq("mid.ins", {32'd0, out_ins}, 64'd0);
        check_eq("mid.pc", {32'd0, out_pc}, 64'd0);
        check_eq("mid.busy", {63'd0, busy}, 64'd0);
        check_eq("mid.fault", {63'd0, fault}, 64'd0);
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); expect_out("post0", 32'h0, 32'h11);
        tick(); expect_out("post1", 32'h4, 32'h22);
        tick(); expect_out("post2", 32'h8, 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks_s, errors_s);
        $finish;
    end

endmodule
